// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM state encoding,
// frame geometry constants and the even-parity helper.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Returns 1 when the byte has an odd number of ones (the even-parity bit).
    function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous byte FIFO with a registered head output that updates in
// the same edge as a pop, so the next entry is visible one cycle later.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             enable,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_nxt;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = data_q;

    // A push into a full FIFO is only accepted when a pop frees a slot in the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rd_nxt  = ptr_inc(rd_ptr_q);

    always_comb begin
        rd_ptr_d = do_pop  ? rd_nxt : rd_ptr_q;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        data_d   = data_q;
        if (count_d != '0) begin
            if (do_pop) begin
                data_d = (count_q == CW'(1)) ? push_data_i : mem[rd_nxt];
            end else if (count_q == '0) begin
                data_d = push_data_i;
            end else begin
                data_d = mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (enable) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchronises rx_in, times an 11-bit 8E1 frame from the
// mid-point of the start bit, checks parity/stop and queues good bytes.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      enable,
    input  logic                      rx_in,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      parity_err,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      sync1_q, sync2_q;
    logic                      rxs;
    rx_state_t                 state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      par_ok_q, par_ok_d;
    logic                      perr_q, perr_d;
    logic                      ferr_q, ferr_d;
    logic                      ovr_q, ovr_d;
    logic                      cnt_zero;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;

    assign rxs      = sync2_q;
    assign cnt_zero = (cnt_q == '0);
    assign fifo_pop = !fifo_empty && rx_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        fifo_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    cnt_d   = CNT_HALF;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rxs) begin
                    cnt_d     = CNT_FULL;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d[bit_idx_q] = rxs;
                    cnt_d              = CNT_FULL;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    par_ok_d = ((uart_parity(shift_q) ^ rxs) == 1'b0);
                    cnt_d    = CNT_FULL;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Framing beats parity beats overrun; only a clean frame is pushed.
                    state_d = ST_IDLE;
                    if (!rxs) begin
                        ferr_d = 1'b1;
                    end else if (!par_ok_q) begin
                        perr_d = 1'b1;
                    end else if (fifo_full && !fifo_pop) begin
                        ovr_d = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (enable) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_ok_q  <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= rx_in;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk         (clk),
        .enable      (enable),
        .push_i      (fifo_push),
        .push_data_i (shift_q),
        .pop_i       (fifo_pop),
        .data_o      (rx_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign rx_valid   = !fifo_empty;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: table-driven frames, hand-written corner sequences
// and random frames, all checked every cycle against a queue-based model.
module tb_uart_rx_ctrl;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       enable = 1'b1;
    logic       rx_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, overrun, busy;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .enable     (enable),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: pending frame outcomes, byte queue, expected busy windows.
    typedef struct {
        int         ev;
        logic [7:0] data;
        bit         stop;
        bit         par_ok;
    } pend_t;

    pend_t      pf[$];
    logic [7:0] mq[$];
    logic [7:0] got_q[$];
    logic [7:0] last_data = 8'h00;
    int         busy_lo = 0, busy_hi = -1;
    int         busy2_lo = 0, busy2_hi = -1;
    bit         exp_perr = 1'b0, exp_ferr = 1'b0, exp_ovr = 1'b0;
    bit         mon_on = 1'b0;
    bit         rand_ready = 1'b0;
    bit         ready_fix = 1'b1;
    logic       snap_perr, snap_ferr, snap_ovr, snap_valid, snap_busy;

    task automatic monitor_cycle();
        int         c;
        bit         pop, pn, fn, on, do_push, busy_exp;
        logic [7:0] edata, pdata;
        pend_t      f;
        c = cyc;
        pn = 1'b0; fn = 1'b0; on = 1'b0; do_push = 1'b0; pdata = 8'h00;
        busy_exp = (c >= busy_lo && c <= busy_hi) || (c >= busy2_lo && c <= busy2_hi);
        edata = (mq.size() > 0) ? mq[0] : last_data;
        check("busy", 32'(busy), 32'(busy_exp));
        check("rx_valid", 32'(rx_valid), 32'(mq.size() > 0));
        check("rx_data", 32'(rx_data), 32'(edata));
        check("parity_err", 32'(parity_err), 32'(exp_perr));
        check("frame_err", 32'(frame_err), 32'(exp_ferr));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            got_q.push_back(rx_data);
            $display("pop   cycle=%0d data=%02h", c, rx_data);
        end
        if (enable) begin
            mq.delete();
            pf.delete();
            busy_hi = -1;
            busy2_hi = -1;
            last_data = 8'h00;
        end else begin
            pop = rx_ready && (mq.size() > 0);
            if (pf.size() > 0 && pf[0].ev == c + 1) begin
                f = pf.pop_front();
                if (!f.stop) fn = 1'b1;
                else if (!f.par_ok) pn = 1'b1;
                else if (mq.size() == DEPTH && !pop) on = 1'b1;
                else begin
                    do_push = 1'b1;
                    pdata = f.data;
                end
            end
            if (pop) void'(mq.pop_front());
            if (do_push) mq.push_back(pdata);
            if (mq.size() > 0) last_data = mq[0];
        end
        exp_perr = pn;
        exp_ferr = fn;
        exp_ovr  = on;
    endtask

    initial forever begin
        @(negedge clk);
        if (mon_on) monitor_cycle();
    end

    initial forever begin
        @(posedge clk);
        #2;
        rx_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end

    task automatic at_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    // Drives one frame; abort_k >= 0 pulses enable at that cycle of the frame instead.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop,
                              input int gap, input int abort_k);
        int          c0, e;
        logic        pbit;
        bit          par_ok;
        logic [10:0] bits;
        c0 = 0;
        e = -1;
        pbit = 1'($countones(d) % 2) ^ bad_par;
        par_ok = (($countones(d) + int'(pbit)) % 2) == 0;
        bits = {stop, pbit, d, 1'b0};
        for (int k = 0; k < 11 * CPB + gap; k++) begin
            @(posedge clk);
            #2;
            if (k == 0) begin
                c0 = cyc;
                e = c0 + 171;
                busy_lo = c0 + 3;
                busy_hi = c0 + 170;
                busy2_lo = c0 + 172;
                busy2_hi = stop ? -1 : c0 + 179;
                pf.push_back('{ev: e, data: d, stop: stop, par_ok: par_ok});
            end
            if (k == abort_k) begin
                rx_in = 1'b1;
                enable = 1'b1;
                @(posedge clk);
                #2;
                enable = 1'b0;
                $display("frame data=%02h aborted by enable at cycle %0d", d, c0 + k);
                return;
            end
            rx_in = (k < 11 * CPB) ? bits[k / CPB] : 1'b1;
            if (cyc == e) begin
                @(negedge clk);
                snap_perr = parity_err;
                snap_ferr = frame_err;
                snap_ovr = overrun;
                snap_valid = rx_valid;
                snap_busy = busy;
            end
        end
        $display("frame data=%02h par=%0b stop=%0b -> perr=%0b ferr=%0b ovr=%0b valid=%0b",
                 d, pbit, stop, snap_perr, snap_ferr, snap_ovr, snap_valid);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         stop;
        bit         ready;
        bit         exp_perr;
        bit         exp_ferr;
        bit         exp_valid;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int c0;
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h7E, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #2 mon_on = 1'b1;
        repeat (3) @(posedge clk);
        #2 enable = 1'b0;
        @(negedge clk);
        check("reset rx_valid", 32'(rx_valid), 32'(0));
        check("reset rx_data", 32'(rx_data), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset errs", 32'({parity_err, frame_err, overrun}), 32'(0));

        for (int i = 0; i < 8; i++) begin
            ready_fix = vecs[i].ready;
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop, 8, -1);
            check($sformatf("vec%0d parity_err", i), 32'(snap_perr), 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d frame_err", i), 32'(snap_ferr), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d rx_valid", i), 32'(snap_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d overrun", i), 32'(snap_ovr), 32'(0));
            check($sformatf("vec%0d busy", i), 32'(snap_busy), 32'(0));
        end

        // Glitch: four low cycles must be rejected at the start midpoint.
        @(posedge clk);
        #2;
        c0 = cyc;
        busy_lo = c0 + 3;
        busy_hi = c0 + 10;
        rx_in = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #2;
        end
        rx_in = 1'b1;
        $display("glitch 4 cycles at cycle %0d", c0);
        at_cycle(c0 + 10);
        check("glitch busy in START", 32'(busy), 32'(1));
        at_cycle(c0 + 11);
        check("glitch busy after abort", 32'(busy), 32'(0));
        at_cycle(c0 + 40);
        check("glitch rx_valid", 32'(rx_valid), 32'(0));

        // Overrun: five frames with the consumer stalled.
        ready_fix = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 8, -1);
            check($sformatf("ovr frame%0d overrun", i), 32'(snap_ovr), 32'(i == 4));
        end
        got_q.delete();
        ready_fix = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("drain count", 32'(got_q.size()), 32'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) check($sformatf("drain[%0d]", i), 32'(got_q[i]), 32'(8'h10 + 8'(i)));
        end
        check("drain rx_valid", 32'(rx_valid), 32'(0));

        // Reset in the middle of data bit 3 with two bytes queued.
        ready_fix = 1'b0;
        send_frame(8'h21, 1'b0, 1'b1, 8, -1);
        send_frame(8'h22, 1'b0, 1'b1, 8, -1);
        check("pre-reset rx_valid", 32'(rx_valid), 32'(1));
        send_frame(8'h9A, 1'b0, 1'b1, 8, 65);
        @(negedge clk);
        check("post-reset rx_valid", 32'(rx_valid), 32'(0));
        check("post-reset busy", 32'(busy), 32'(0));
        check("post-reset rx_data", 32'(rx_data), 32'(0));
        got_q.delete();
        ready_fix = 1'b1;
        repeat (6) @(posedge clk);
        send_frame(8'hC3, 1'b0, 1'b1, 8, -1);
        check("after reset count", 32'(got_q.size()), 32'(1));
        if (got_q.size() > 0) check("after reset data", 32'(got_q[0]), 32'(8'hC3));

        // Random frames against the model with a randomly stalling consumer.
        rand_ready = 1'b1;
        repeat (40) begin
            send_frame(8'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) != 0),
                       int'($urandom_range(4, 40)), -1);
        end
        rand_ready = 1'b0;
        ready_fix = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
